// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the word-level pattern scan controller.
// The PATTERN_SCAN_CNT_EN macro adds per-word match counters to the detector.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [2:0] PAT_111 = 3'b111;
  localparam logic [2:0] PAT_001 = 3'b001;

  localparam int FLAG_111 = 0;
  localparam int FLAG_001 = 1;

  localparam logic [1:0] FILL_FULL = 2'd2;

endpackage

// File: rtl/pattern_detector.sv
// Serial Mealy detector for "111" and "001" with sticky flags and a history fill counter.
// Define PATTERN_SCAN_CNT_EN to keep per-word occurrence counters; otherwise counts are tied to 0.
module pattern_detector
  import pattern_scan_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [1:0]       flags,
  output logic [1:0]       flags_nxt,
  output logic [CNT_W-1:0] cnt111_nxt,
  output logic [CNT_W-1:0] cnt001_nxt
);

  logic [1:0] hist;
  logic [1:0] fill;
  logic [2:0] win;
  logic       qual;
  logic       hit111;
  logic       hit001;

  // Only windows made entirely of this word's bits may match, so the cleared
  // zero history can never fake a "001" at bit index 0 or 1.
  always_comb begin
    win                 = {hist, bit_in};
    qual                = (fill == FILL_FULL);
    hit111              = en & qual & (win == PAT_111);
    hit001              = en & qual & (win == PAT_001);
    flags_nxt           = flags;
    flags_nxt[FLAG_111] = flags[FLAG_111] | hit111;
    flags_nxt[FLAG_001] = flags[FLAG_001] | hit001;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist  <= 2'b00;
      fill  <= 2'd0;
      flags <= 2'b00;
    end else if (clr) begin
      hist  <= 2'b00;
      fill  <= 2'd0;
      flags <= 2'b00;
    end else if (en) begin
      hist  <= {hist[0], bit_in};
      fill  <= qual ? fill : fill + 2'd1;
      flags <= flags_nxt;
    end
  end

`ifdef PATTERN_SCAN_CNT_EN
  logic [CNT_W-1:0] cnt111;
  logic [CNT_W-1:0] cnt001;

  // Overlapping matches each count; at most WIDTH-2 per word, so no saturation.
  always_comb begin
    cnt111_nxt = cnt111 + CNT_W'(hit111);
    cnt001_nxt = cnt001 + CNT_W'(hit001);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt111 <= '0;
      cnt001 <= '0;
    end else if (clr) begin
      cnt111 <= '0;
      cnt001 <= '0;
    end else if (en) begin
      cnt111 <= cnt111_nxt;
      cnt001 <= cnt001_nxt;
    end
  end
`else
  assign cnt111_nxt = '0;
  assign cnt001_nxt = '0;
`endif

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-level controller: accepts a word, feeds it MSB first into pattern_detector, reports the result.
// Counter outputs are live only when PATTERN_SCAN_CNT_EN is defined; otherwise they stay 0.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for a word
// SHIFT  | one bit per cycle into the detector, WIDTH cycles
// REPORT | out_valid=1, results held until out_ready
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_flags,
  output logic [CNT_W-1:0] out_cnt111,
  output logic [CNT_W-1:0] out_cnt001
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [IDX_W-1:0] idx;

  logic             det_clr;
  logic             det_en;
  logic [1:0]       det_flags;
  logic [1:0]       det_flags_nxt;
  logic [CNT_W-1:0] det_cnt111_nxt;
  logic [CNT_W-1:0] det_cnt001_nxt;

  assign det_clr = (state == IDLE) && in_valid;
  assign det_en  = (state == SHIFT);

  pattern_detector #(
    .CNT_W (CNT_W)
  ) u_det (
    .clock      (clock),
    .reset_n    (reset_n),
    .clr        (det_clr),
    .en         (det_en),
    .bit_in     (sr[WIDTH-1]),
    .flags      (det_flags),
    .flags_nxt  (det_flags_nxt),
    .cnt111_nxt (det_cnt111_nxt),
    .cnt001_nxt (det_cnt001_nxt)
  );

  // Result registers capture the detector's post-last-bit values, so they hold
  // through the next word's clear until the next REPORT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sr         <= '0;
      idx        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_flags  <= 2'b00;
      out_cnt111 <= '0;
      out_cnt001 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr       <= in_data;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= {sr[WIDTH-2:0], 1'b0};
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            out_flags  <= det_flags_nxt;
            out_cnt111 <= det_cnt111_nxt;
            out_cnt001 <= det_cnt001_nxt;
            out_valid  <= 1'b1;
            state      <= REPORT;
          end
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  logic unused_det_flags;
  assign unused_det_flags = ^det_flags;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl (WIDTH=8); expected counts follow PATTERN_SCAN_CNT_EN.
module tb_pattern_scan_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef PATTERN_SCAN_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_flags;
  logic [CNT_W-1:0] out_cnt111;
  logic [CNT_W-1:0] out_cnt001;

  int checks = 0;
  int failures = 0;

  pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_flags  (out_flags),
    .out_cnt111 (out_cnt111),
    .out_cnt001 (out_cnt001)
  );

  always #5 clock = ~clock;

  function automatic logic [CNT_W-1:0] ecnt(input int n);
    return CNT_ON ? CNT_W'(n) : '0;
  endfunction

  // Offers one word, waits for REPORT, checks the result, then retires it.
  task automatic run_word(input logic [7:0] w, input logic [1:0] ef, input int e111,
                          input int e001, input string nm);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL %s in_ready_before_accept got=%b exp=1", nm, in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    n = 1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL %s in_ready_in_shift got=%b exp=0", nm, in_ready);
    end
    while (out_valid !== 1'b1 && n < 30) begin
      @(posedge clock); #1; n++;
    end
    checks++;
    if (n !== WIDTH + 1) begin
      failures++; $display("FAIL %s out_valid_latency got=%0d exp=%0d", nm, n, WIDTH + 1);
    end
    checks++;
    if (out_flags !== ef) begin
      failures++; $display("FAIL %s flags got=%b exp=%b", nm, out_flags, ef);
    end
    checks++;
    if (out_cnt111 !== ecnt(e111)) begin
      failures++; $display("FAIL %s cnt111 got=%0d exp=%0d", nm, out_cnt111, ecnt(e111));
    end
    checks++;
    if (out_cnt001 !== ecnt(e001)) begin
      failures++; $display("FAIL %s cnt001 got=%0d exp=%0d", nm, out_cnt001, ecnt(e001));
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s back_to_idle valid=%b ready=%b exp valid=0 ready=1", nm, out_valid, in_ready);
    end
    checks++;
    if (out_flags !== ef) begin
      failures++; $display("FAIL %s flags_held_in_idle got=%b exp=%b", nm, out_flags, ef);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_flags !== 2'b00 ||
        out_cnt111 !== '0 || out_cnt001 !== '0) begin
      failures++;
      $display("FAIL reset_values ready=%b valid=%b flags=%b c111=%0d c001=%0d exp 1 0 00 0 0",
               in_ready, out_valid, out_flags, out_cnt111, out_cnt001);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    run_word(8'b00111110, 2'b11, 3, 1, "basic_00111110");
    run_word(8'b11111111, 2'b01, 6, 0, "all_ones");
  endtask

  task automatic test_back_to_back();
    run_word(8'b00000000, 2'b00, 0, 0, "zeros");
    run_word(8'b10000000, 2'b00, 0, 0, "no_carry_10000000");
    run_word(8'b00100000, 2'b10, 0, 1, "no_false_001");
  endtask

  task automatic test_stall();
    int n;
    logic [1:0] f0;
    in_valid = 1'b1;
    in_data  = 8'b11100000;
    @(posedge clock); #1;
    in_data = 8'b00100000;
    n = 1;
    while (out_valid !== 1'b1 && n < 30) begin
      @(posedge clock); #1; n++;
    end
    checks++;
    if (out_flags !== 2'b01 || out_cnt111 !== ecnt(1)) begin
      failures++;
      $display("FAIL stall_first_word flags=%b c111=%0d exp 01 %0d", out_flags, out_cnt111, ecnt(1));
    end
    f0 = out_flags;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_flags !== f0 || out_cnt111 !== ecnt(1)) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d valid=%b ready=%b flags=%b c111=%0d exp 1 0 %b %0d",
                 i, out_valid, in_ready, out_flags, out_cnt111, f0, ecnt(1));
      end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release ready=%b valid=%b exp 1 0", in_ready, out_valid);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 30) begin
      @(posedge clock); #1; n++;
    end
    checks++;
    if (n !== WIDTH + 1 || out_flags !== 2'b10 || out_cnt001 !== ecnt(1)) begin
      failures++;
      $display("FAIL stall_second_word lat=%0d flags=%b c001=%0d exp %0d 10 %0d",
               n, out_flags, out_cnt001, WIDTH + 1, ecnt(1));
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    in_valid = 1'b1;
    in_data  = 8'b00111110;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_flags !== 2'b00 ||
        out_cnt111 !== '0 || out_cnt001 !== '0) begin
      failures++;
      $display("FAIL mid_shift_reset ready=%b valid=%b flags=%b c111=%0d c001=%0d exp 1 0 00 0 0",
               in_ready, out_valid, out_flags, out_cnt111, out_cnt001);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_word(8'b00111110, 2'b11, 3, 1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
